dram_arbiter: RTL and testbench

- Sits downstream of the NCORES processor cores and upstream of the single shared data RAM.
- Serialises each core's memREAD/memWRITE request onto the one DRAM port using round-robin arbitration.
- Returns read data on a shared data-in bus.
- Pulses the per-core memAV completion strobe that each core's control unit waits on.

---
 rtl/dram_arbiter.sv | 149 ++++++++++++++
 tb/tb_dram_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_arbiter.sv
// Round-robin arbiter that serialises per-core read/write requests onto one
// synchronous-read DRAM port and returns a one-cycle completion strobe per core.
module dram_arbiter #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NCORES = 4,
  parameter int unsigned IDW    = 3
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic [NCORES-1:0]       core_memREAD,
  input  logic [NCORES-1:0]       core_memWRITE,
  input  logic [NCORES*WIDTH-1:0] core_addr,
  input  logic [NCORES*WIDTH-1:0] core_wdata,
  output logic [NCORES-1:0]       core_memAV,
  output logic [WIDTH-1:0]        core_rdata,
  output logic [WIDTH-1:0]        dram_addr,
  output logic [WIDTH-1:0]        dram_wdata,
  output logic                    dram_we,
  input  logic [WIDTH-1:0]        dram_rdata,
  output logic                    busy,
  output logic [IDW-1:0]          gnt_id
);

  localparam int unsigned SLOTS = 2 ** IDW;
  localparam int unsigned SW    = IDW + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_CAPTURE = 2'd2,
    S_ACK     = 2'd3
  } state_e;

  state_e            state_q;
  logic [IDW-1:0]    rr_ptr_q;
  logic [IDW-1:0]    gnt_q;
  logic [NCORES-1:0] mask_q;
  logic [NCORES-1:0] memav_q;
  logic [WIDTH-1:0]  addr_q;
  logic [WIDTH-1:0]  wdata_q;
  logic [WIDTH-1:0]  rdata_q;
  logic              op_q;
  logic              we_q;
  logic              busy_q;

  // Per-slot views padded to a power of two so the grant index selects exactly.
  logic [SLOTS-1:0] req_ext;
  logic [SLOTS-1:0] wr_ext;
  logic [WIDTH-1:0] addr_arr  [SLOTS];
  logic [WIDTH-1:0] wdata_arr [SLOTS];

  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    if (i < NCORES) begin : g_core
      assign req_ext[i]   = (core_memREAD[i] | core_memWRITE[i]) & ~mask_q[i];
      assign wr_ext[i]    = core_memWRITE[i];
      assign addr_arr[i]  = core_addr[i*WIDTH +: WIDTH];
      assign wdata_arr[i] = core_wdata[i*WIDTH +: WIDTH];
    end else begin : g_pad
      assign req_ext[i]   = 1'b0;
      assign wr_ext[i]    = 1'b0;
      assign addr_arr[i]  = '0;
      assign wdata_arr[i] = '0;
    end
  end

  // Round-robin search starting at rr_ptr_q, wrapping modulo NCORES.
  logic           win_d;
  logic [IDW-1:0] win_id_d;
  logic [SW-1:0]  sum_d;
  logic [IDW-1:0] idx_d;

  always_comb begin
    win_d    = 1'b0;
    win_id_d = '0;
    sum_d    = '0;
    idx_d    = '0;
    for (int unsigned k = 0; k < NCORES; k++) begin
      sum_d = {1'b0, rr_ptr_q} + SW'(k);
      if (sum_d >= SW'(NCORES)) begin
        sum_d = sum_d - SW'(NCORES);
      end
      idx_d = sum_d[IDW-1:0];
      if (!win_d && req_ext[idx_d]) begin
        win_d    = 1'b1;
        win_id_d = idx_d;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      mask_q   <= '0;
      memav_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      op_q     <= 1'b0;
      we_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          mask_q <= '0;
          if (win_d) begin
            gnt_q   <= win_id_d;
            addr_q  <= addr_arr[win_id_d];
            wdata_q <= wdata_arr[win_id_d];
            op_q    <= wr_ext[win_id_d];
            we_q    <= wr_ext[win_id_d];
            busy_q  <= 1'b1;
            state_q <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          we_q    <= 1'b0;
          state_q <= S_CAPTURE;
        end
        S_CAPTURE: begin
          if (!op_q) begin
            rdata_q <= dram_rdata;
          end
          memav_q <= NCORES'(1) << gnt_q;
          state_q <= S_ACK;
        end
        S_ACK: begin
          memav_q  <= '0;
          busy_q   <= 1'b0;
          rr_ptr_q <= (gnt_q == IDW'(NCORES - 1)) ? '0 : gnt_q + IDW'(1);
          // Hide the just-served core for one IDLE cycle while it drops its request.
          mask_q   <= NCORES'(1) << gnt_q;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign core_memAV = memav_q;
  assign core_rdata = rdata_q;
  assign dram_addr  = addr_q;
  assign dram_wdata = wdata_q;
  assign dram_we    = we_q;
  assign busy       = busy_q;
  assign gnt_id     = gnt_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: transaction-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_dram_arbiter;

  localparam int unsigned W   = 8;
  localparam int unsigned N   = 4;
  localparam int unsigned IDW = 3;

  logic           Clk = 1'b0;
  logic           Rst_n = 1'b0;
  logic [N-1:0]   rd = '0;
  logic [N-1:0]   wr = '0;
  logic [N*W-1:0] addr_bus = '0;
  logic [N*W-1:0] wdata_bus = '0;
  logic [N-1:0]   core_memAV;
  logic [W-1:0]   core_rdata;
  logic [W-1:0]   dram_addr;
  logic [W-1:0]   dram_wdata;
  logic [W-1:0]   dram_rdata;
  logic           dram_we;
  logic           busy;
  logic [IDW-1:0] gnt_id;

  logic           bd_en = 1'b0;
  logic [7:0]     bd_addr = '0;
  logic [7:0]     bd_data = '0;
  logic [N-1:0]   sticky = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int we_cnt   = 0;
  logic [7:0] we_addr = '0;
  logic [7:0] we_data = '0;
  int grants[$];
  int av_cyc[$];
  logic [7:0] rd_seen [N];

  dram_arbiter #(.WIDTH(W), .NCORES(N), .IDW(IDW)) dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .core_memREAD (rd),
    .core_memWRITE(wr),
    .core_addr    (addr_bus),
    .core_wdata   (wdata_bus),
    .core_memAV   (core_memAV),
    .core_rdata   (core_rdata),
    .dram_addr    (dram_addr),
    .dram_wdata   (dram_wdata),
    .dram_we      (dram_we),
    .dram_rdata   (dram_rdata),
    .busy         (busy),
    .gnt_id       (gnt_id)
  );

  initial forever #5 Clk = ~Clk;

  // Synchronous-read RAM with a backdoor load port.
  logic [7:0] ram [256];
  always @(posedge Clk) begin
    if (bd_en) ram[bd_addr] <= bd_data;
    else if (dram_we) ram[dram_addr] <= dram_wdata;
    dram_rdata <= ram[dram_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks one transaction at a time by its age in cycles since grant.
  int         age = 0;
  int         ptr = 0;
  int         masked = -1;
  int         m_gnt = 0;
  logic [7:0] m_addr = '0;
  logic [7:0] m_wdata = '0;
  logic [7:0] m_rdata = '0;
  logic [7:0] m_rd_val = '0;
  bit         m_wr = 1'b0;
  logic [7:0] ref_mem [256];

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    forever begin
      @(posedge Clk or negedge Rst_n);
      if (!Rst_n) begin
        age = 0; ptr = 0; masked = -1; m_gnt = 0;
        m_addr = '0; m_wdata = '0; m_rdata = '0; m_wr = 1'b0;
      end else begin
        if (bd_en) ref_mem[bd_addr] = bd_data;
        if (age == 0) begin
          int pick;
          pick = -1;
          for (int k = 0; k < N; k++) begin
            int c;
            c = (ptr + k) % N;
            if (pick < 0 && c != masked && (rd[c[1:0]] || wr[c[1:0]])) pick = c;
          end
          masked = -1;
          if (pick >= 0) begin
            m_gnt   = pick;
            m_addr  = addr_bus[pick*W +: W];
            m_wdata = wdata_bus[pick*W +: W];
            m_wr    = wr[pick[1:0]];
            age     = 1;
          end
        end else if (age == 1) begin
          if (m_wr) ref_mem[m_addr] = m_wdata;
          else m_rd_val = ref_mem[m_addr];
          age = 2;
        end else if (age == 2) begin
          if (!m_wr) m_rdata = m_rd_val;
          age = 3;
        end else begin
          ptr    = (m_gnt + 1) % N;
          masked = m_gnt;
          age    = 0;
        end
      end
    end
  end

  // Every-cycle comparison against the model, plus event logging.
  initial forever begin
    logic [N-1:0] exp_av;
    @(negedge Clk);
    cyc++;
    exp_av = (age == 3) ? N'(1) << m_gnt : '0;
    check("memAV", 32'(core_memAV), 32'(exp_av));
    check("dram_we", 32'(dram_we), 32'(age == 1 && m_wr));
    check("busy", 32'(busy), 32'(age != 0));
    check("gnt_id", 32'(gnt_id), 32'(m_gnt));
    check("dram_addr", 32'(dram_addr), 32'(m_addr));
    check("dram_wdata", 32'(dram_wdata), 32'(m_wdata));
    check("core_rdata", 32'(core_rdata), 32'(m_rdata));
    if (dram_we) begin
      we_cnt++;
      we_addr = dram_addr;
      we_data = dram_wdata;
    end
    for (int i = 0; i < N; i++) begin
      if (core_memAV[i[1:0]]) begin
        grants.push_back(i);
        av_cyc.push_back(cyc);
        rd_seen[i[1:0]] = core_rdata;
      end
    end
  end

  // Advance one cycle; cores drop their request on seeing memAV unless held sticky.
  task automatic step();
    @(negedge Clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (core_memAV[i[1:0]] && !sticky[i[1:0]]) begin
        rd[i[1:0]] = 1'b0;
        wr[i[1:0]] = 1'b0;
      end
    end
  endtask

  task automatic set_req(input logic [1:0] c, input bit w, input bit r,
                         input logic [7:0] a, input logic [7:0] d);
    rd[c] = r;
    wr[c] = w;
    addr_bus[{c, 3'b000} +: W]  = a;
    wdata_bus[{c, 3'b000} +: W] = d;
  endtask

  task automatic backdoor(input logic [7:0] a, input logic [7:0] d);
    bd_addr = a;
    bd_data = d;
    bd_en   = 1'b1;
    step();
    bd_en   = 1'b0;
  endtask

  task automatic wait_av(input logic [1:0] c, output int lat);
    lat = 0;
    for (int t = 0; t < 16; t++) begin
      step();
      lat++;
      if (core_memAV[c]) return;
    end
    check("memAV_timeout", 32'(lat), 32'(0));
  endtask

  task automatic wait_grants(input int n);
    for (int t = 0; t < 40 && grants.size() < n; t++) step();
    check("grant_count", 32'(grants.size()), 32'(n));
  endtask

  task automatic do_reset();
    step();
    Rst_n = 1'b0;
    step();
    step();
    Rst_n = 1'b1;
  endtask

  initial begin
    int lat;
    int we0;
    repeat (2) @(negedge Clk);
    #1;
    check("rst_gnt", 32'(gnt_id), 32'h0);
    check("rst_rdata", 32'(core_rdata), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_memAV", 32'(core_memAV), 32'h0);
    check("rst_we", 32'(dram_we), 32'h0);
    Rst_n = 1'b1;

    // Single read by core 2
    backdoor(8'h10, 8'h5A);
    for (int i = 0; i < N; i++) backdoor(8'(8'h40 + i), 8'(8'h11 * (i + 1)));
    we0 = we_cnt;
    set_req(2'd2, 1'b0, 1'b1, 8'h10, 8'h00);
    step();
    lat = 1;
    check("t1_access_addr", 32'(dram_addr), 32'h10);
    check("t1_busy", 32'(busy), 32'h1);
    step(); step();
    lat += 2;
    check("t1_latency", 32'(lat), 32'd3);
    check("t1_memAV", 32'(core_memAV), 32'b0100);
    check("t1_rdata", 32'(core_rdata), 32'h5A);
    check("t1_no_write", 32'(we_cnt - we0), 32'd0);

    // Single write by core 1, read back by core 0
    step();
    we0 = we_cnt;
    set_req(2'd1, 1'b1, 1'b0, 8'h22, 8'hC3);
    wait_av(2'd1, lat);
    check("t2_memAV", 32'(core_memAV), 32'b0010);
    check("t2_we_pulses", 32'(we_cnt - we0), 32'd1);
    check("t2_we_addr", 32'(we_addr), 32'h22);
    check("t2_we_data", 32'(we_data), 32'hC3);
    step();
    set_req(2'd0, 1'b0, 1'b1, 8'h22, 8'h00);
    wait_av(2'd0, lat);
    check("t2_readback", 32'(core_rdata), 32'hC3);

    // All four cores at once from a fresh pointer
    do_reset();
    grants.delete();
    av_cyc.delete();
    for (int i = 0; i < N; i++) set_req(i[1:0], 1'b0, 1'b1, 8'(8'h40 + i), 8'h00);
    wait_grants(N);
    if (grants.size() >= N) begin
      for (int i = 0; i < N; i++) begin
        check("t3_order", 32'(grants[i]), 32'(i));
        check("t3_data", 32'(rd_seen[i[1:0]]), 32'(8'h11 * (i + 1)));
        if (i > 0) check("t3_spacing", 32'(av_cyc[i] - av_cyc[i-1]), 32'd4);
      end
    end

    // Pointer wrapped to 0: core 1 beats core 3
    step();
    grants.delete();
    set_req(2'd3, 1'b0, 1'b1, 8'h43, 8'h00);
    set_req(2'd1, 1'b0, 1'b1, 8'h41, 8'h00);
    wait_grants(2);
    if (grants.size() >= 2) begin
      check("t3b_first", 32'(grants[0]), 32'd1);
      check("t3b_second", 32'(grants[1]), 32'd3);
    end

    // Sticky core 3 with core 0 waiting: no double service
    step();
    grants.delete();
    sticky[3] = 1'b1;
    set_req(2'd3, 1'b0, 1'b1, 8'h41, 8'h00);
    wait_av(2'd3, lat);
    set_req(2'd0, 1'b0, 1'b1, 8'h42, 8'h00);
    step();
    sticky[3] = 1'b0;
    rd[3] = 1'b0;
    wait_av(2'd0, lat);
    check("t4_rdata", 32'(core_rdata), 32'h33);
    step();
    step();
    check("t4_grants", 32'(grants.size()), 32'd2);
    if (grants.size() >= 2) check("t4_next", 32'(grants[1]), 32'd0);

    // Sticky core 3 alone past the mask cycle is served again
    grants.delete();
    sticky[3] = 1'b1;
    set_req(2'd3, 1'b0, 1'b1, 8'h43, 8'h00);
    wait_av(2'd3, lat);
    step(); step(); step();
    sticky[3] = 1'b0;
    rd[3] = 1'b0;
    wait_av(2'd3, lat);
    check("t4b_reserved", 32'(grants.size()), 32'd2);

    // Read and write together count as a write
    step();
    we0 = we_cnt;
    set_req(2'd1, 1'b1, 1'b1, 8'h30, 8'h99);
    wait_av(2'd1, lat);
    check("t5_we_pulses", 32'(we_cnt - we0), 32'd1);
    check("t5_we_data", 32'(we_data), 32'h99);
    step();
    set_req(2'd2, 1'b0, 1'b1, 8'h30, 8'h00);
    wait_av(2'd2, lat);
    check("t5_readback", 32'(core_rdata), 32'h99);

    // Reset during a write's ACCESS cycle
    step();
    grants.delete();
    set_req(2'd3, 1'b1, 1'b0, 8'h50, 8'h77);
    step();
    check("t6_we_before", 32'(dram_we), 32'h1);
    check("t6_addr_before", 32'(dram_addr), 32'h50);
    Rst_n = 1'b0;
    #1;
    check("t6_we_abort", 32'(dram_we), 32'h0);
    check("t6_busy_abort", 32'(busy), 32'h0);
    check("t6_gnt_abort", 32'(gnt_id), 32'h0);
    check("t6_rdata_abort", 32'(core_rdata), 32'h0);
    check("t6_av_abort", 32'(core_memAV), 32'h0);
    set_req(2'd1, 1'b0, 1'b1, 8'h40, 8'h00);
    step(); step();
    Rst_n = 1'b1;
    wait_grants(2);
    if (grants.size() >= 2) begin
      check("t6_first", 32'(grants[0]), 32'd1);
      check("t6_second", 32'(grants[1]), 32'd3);
    end
    step();
    set_req(2'd0, 1'b0, 1'b1, 8'h50, 8'h00);
    wait_av(2'd0, lat);
    check("t6_readback", 32'(core_rdata), 32'h77);
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
